// File: rtl/game_board_judge.sv
// 3x3 board store and sequential win/draw judge for the game controller.
// Optional score counters are enabled with the GAME_BOARD_SCORE_EN macro.
module game_board_judge #(
    parameter bit ALLOW_OVERWRITE = 1'b0
`ifdef GAME_BOARD_SCORE_EN
    , parameter int SCORE_W = 4
`endif
) (
    input  logic       ph1,
    input  logic       reset_n,
    input  logic       wrEn,
    input  logic [3:0] addr,
    input  logic [1:0] cellState,
    input  logic       newGame,
    input  logic [3:0] rdAddr,
    output logic [1:0] rdState,
    output logic       wrAck,
    output logic       wrReject,
    output logic       checkBusy,
    output logic       gameIsDone,
    output logic [1:0] winner
`ifdef GAME_BOARD_SCORE_EN
    , output logic [SCORE_W-1:0] xWins
    , output logic [SCORE_W-1:0] oWins
    , output logic [SCORE_W-1:0] draws
`endif
);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b10;
    localparam logic [1:0] CELL_O     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t      state_r;
    logic [17:0] board_r;
    logic [2:0]  line_idx_r;
    logic        found_r;
    logic [1:0]  cand_r;
    logic [1:0]  winner_r;
    logic        wr_ack_r;
    logic        wr_reject_r;

    logic [1:0]  line_result_s;
    logic [1:0]  final_win_s;
    logic        board_full_s;
    logic        wr_ok_s;

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] a);
        logic [1:0] c;
        if (a <= 4'd8) c = b[{a, 1'b0} +: 2];
        else c = CELL_EMPTY;
        return c;
    endfunction

    // Line order: rows, then columns, then the two diagonals.
    function automatic logic [1:0] line_winner(input logic [17:0] b, input logic [2:0] idx);
        logic [11:0] cells;
        logic [1:0]  c0, c1, c2, res;
        case (idx)
            3'd0:    cells = {4'd0, 4'd1, 4'd2};
            3'd1:    cells = {4'd3, 4'd4, 4'd5};
            3'd2:    cells = {4'd6, 4'd7, 4'd8};
            3'd3:    cells = {4'd0, 4'd3, 4'd6};
            3'd4:    cells = {4'd1, 4'd4, 4'd7};
            3'd5:    cells = {4'd2, 4'd5, 4'd8};
            3'd6:    cells = {4'd0, 4'd4, 4'd8};
            3'd7:    cells = {4'd2, 4'd4, 4'd6};
            default: cells = {4'd0, 4'd1, 4'd2};
        endcase
        c0 = cell_of(b, cells[11:8]);
        c1 = cell_of(b, cells[7:4]);
        c2 = cell_of(b, cells[3:0]);
        if (c0 != CELL_EMPTY && c0 == c1 && c1 == c2) res = c0;
        else res = CELL_EMPTY;
        return res;
    endfunction

    // Read port, current line evaluation, board-full flag and write qualification.
    always_comb begin
        rdState       = cell_of(board_r, rdAddr);
        line_result_s = line_winner(board_r, line_idx_r);
        board_full_s  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_r[2*i +: 2] == CELL_EMPTY) board_full_s = 1'b0;
            else board_full_s = board_full_s;
        end
        if (found_r) final_win_s = cand_r;
        else final_win_s = line_result_s;
        wr_ok_s = wrEn && (state_r == ST_IDLE) && (addr <= 4'd8) && cellState[1] &&
                  (ALLOW_OVERWRITE || (cell_of(board_r, addr) == CELL_EMPTY));
    end

    // Judge FSM: board writes, 8-cycle line scan, result latch.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            board_r     <= 18'd0;
            line_idx_r  <= 3'd0;
            found_r     <= 1'b0;
            cand_r      <= CELL_EMPTY;
            winner_r    <= CELL_EMPTY;
            wr_ack_r    <= 1'b0;
            wr_reject_r <= 1'b0;
        end else if (newGame) begin
            state_r     <= ST_IDLE;
            board_r     <= 18'd0;
            line_idx_r  <= 3'd0;
            found_r     <= 1'b0;
            cand_r      <= CELL_EMPTY;
            winner_r    <= CELL_EMPTY;
            wr_ack_r    <= 1'b0;
            wr_reject_r <= 1'b0;
        end else begin
            wr_ack_r    <= wr_ok_s;
            wr_reject_r <= wrEn && !wr_ok_s;
            case (state_r)
                ST_IDLE: begin
                    if (wr_ok_s) begin
                        board_r[{addr, 1'b0} +: 2] <= cellState;
                        line_idx_r <= 3'd0;
                        found_r    <= 1'b0;
                        cand_r     <= CELL_EMPTY;
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!found_r && line_result_s != CELL_EMPTY) begin
                        found_r <= 1'b1;
                        cand_r  <= line_result_s;
                    end
                    if (line_idx_r == 3'd7) begin
                        if (final_win_s != CELL_EMPTY) begin
                            winner_r <= final_win_s;
                            state_r  <= ST_DONE;
                        end else if (board_full_s) begin
                            winner_r <= CELL_EMPTY;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        line_idx_r <= line_idx_r + 3'd1;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign wrAck      = wr_ack_r;
    assign wrReject   = wr_reject_r;
    assign winner     = winner_r;
    assign checkBusy  = (state_r == ST_CHECK);
    assign gameIsDone = (state_r == ST_DONE);

`ifdef GAME_BOARD_SCORE_EN
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == {SCORE_W{1'b1}}) r = v;
        else r = v + {{(SCORE_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // Score counters bump on DONE entry and survive newGame.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            xWins <= {SCORE_W{1'b0}};
            oWins <= {SCORE_W{1'b0}};
            draws <= {SCORE_W{1'b0}};
        end else if (!newGame && state_r == ST_CHECK && line_idx_r == 3'd7) begin
            if (final_win_s == CELL_X) xWins <= sat_inc(xWins);
            else if (final_win_s == CELL_O) oWins <= sat_inc(oWins);
            else if (board_full_s) draws <= sat_inc(draws);
            else draws <= draws;
        end
    end
`endif

endmodule

// File: tb/tb_game_board_judge.sv
// Self-checking bench for game_board_judge: scoreboarded write responses plus
// an independent board model that predicts win/draw results.
module tb_game_board_judge;

    logic       ph1 = 1'b0;
    logic       reset_n;
    logic       wrEn;
    logic [3:0] addr;
    logic [1:0] cellState;
    logic       newGame;
    logic [3:0] rdAddr;
    logic [1:0] rdState;
    logic       wrAck, wrReject, checkBusy, gameIsDone;
    logic [1:0] winner;
`ifdef GAME_BOARD_SCORE_EN
    logic [3:0] xWins, oWins, draws;
`endif

    game_board_judge dut (
        .ph1(ph1), .reset_n(reset_n), .wrEn(wrEn), .addr(addr),
        .cellState(cellState), .newGame(newGame), .rdAddr(rdAddr),
        .rdState(rdState), .wrAck(wrAck), .wrReject(wrReject),
        .checkBusy(checkBusy), .gameIsDone(gameIsDone), .winner(winner)
`ifdef GAME_BOARD_SCORE_EN
        , .xWins(xWins), .oWins(oWins), .draws(draws)
`endif
    );

    always #5 ph1 = ~ph1;

    typedef struct packed {
        logic ack;
        logic rej;
    } resp_t;

    resp_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] mb [0:8];
    bit         m_done;

    function automatic logic [1:0] model_winner();
        int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int k = 0; k < 8; k++)
            if (mb[ln[k][0]] != 2'b00 && mb[ln[k][0]] == mb[ln[k][1]] && mb[ln[k][1]] == mb[ln[k][2]])
                return mb[ln[k][0]];
        return 2'b00;
    endfunction

    function automatic bit model_full();
        for (int k = 0; k < 9; k++) if (mb[k] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 9; k++) mb[k] = 2'b00;
        m_done = 1'b0;
    endtask

    task automatic start_new_game();
        @(negedge ph1); newGame = 1'b1;
        @(negedge ph1); newGame = 1'b0;
        model_clear();
    endtask

    // One move: scoreboarded response, then the full scan latency when accepted.
    task automatic do_move(input logic [3:0] a, input logic [1:0] s);
        resp_t      e;
        logic       acc;
        logic [1:0] w;
        bit         fin;
        acc = 1'b0;
        if (!m_done && a <= 4'd8 && (s == 2'b10 || s == 2'b11))
            acc = (mb[a] == 2'b00);
        @(negedge ph1); wrEn = 1'b1; addr = a; cellState = s;
        exp_q.push_back('{ack: acc, rej: !acc});
        @(negedge ph1); wrEn = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (wrAck !== e.ack || wrReject !== e.rej) begin
            errors++;
            $display("FAIL write_resp addr=%0d st=%b got ack=%b rej=%b exp ack=%b rej=%b",
                     a, s, wrAck, wrReject, e.ack, e.rej);
        end
        if (acc) begin
            mb[a] = s;
            repeat (7) @(negedge ph1);
            checks++;
            if (checkBusy !== 1'b1 || gameIsDone !== 1'b0) begin
                errors++;
                $display("FAIL scan_busy got busy=%b done=%b exp busy=1 done=0", checkBusy, gameIsDone);
            end
            @(negedge ph1);
            w   = model_winner();
            fin = (w != 2'b00) || model_full();
            checks++;
            if (checkBusy !== 1'b0 || gameIsDone !== fin || winner !== w) begin
                errors++;
                $display("FAIL scan_result got busy=%b done=%b win=%b exp busy=0 done=%b win=%b",
                         checkBusy, gameIsDone, winner, fin, w);
            end
            m_done = fin;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wrEn = 1'b0; addr = 4'd0; cellState = 2'b00;
        newGame = 1'b0; rdAddr = 4'd0;
        model_clear();
        repeat (2) @(negedge ph1);
        for (int i = 0; i < 16; i++) begin
            rdAddr = i[3:0];
            #1;
            checks++;
            if (rdState !== 2'b00) begin
                errors++;
                $display("FAIL reset_rd addr=%0d got %b exp 00", i, rdState);
            end
        end
        checks++;
        if ({wrAck, wrReject, checkBusy, gameIsDone, winner} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outs got %b exp 000000", {wrAck, wrReject, checkBusy, gameIsDone, winner});
        end
        @(negedge ph1); reset_n = 1'b1;
    endtask

    task automatic test_row_win();
        do_move(4'd0, 2'b10); do_move(4'd3, 2'b11);
        do_move(4'd1, 2'b10); do_move(4'd4, 2'b11);
        do_move(4'd2, 2'b10);
    endtask

    task automatic test_reject();
        start_new_game();
        do_move(4'd0, 2'b10);
        do_move(4'd4, 2'b11);
        do_move(4'd4, 2'b11);
        do_move(4'd4, 2'b10);
        rdAddr = 4'd4; #1;
        checks++;
        if (rdState !== 2'b11) begin
            errors++;
            $display("FAIL occupied_keep got %b exp 11", rdState);
        end
        do_move(4'd9, 2'b10);
        do_move(4'd15, 2'b11);
        do_move(4'd5, 2'b01);
    endtask

    task automatic test_draw();
        logic [1:0] pat [0:8] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
        start_new_game();
        for (int i = 0; i < 9; i++) do_move(i[3:0], pat[i]);
        do_move(4'd0, 2'b11);
    endtask

    task automatic test_back_to_back();
        resp_t e;
        start_new_game();
        @(negedge ph1); wrEn = 1'b1; addr = 4'd4; cellState = 2'b10;
        exp_q.push_back('{ack: 1'b1, rej: 1'b0});
        @(negedge ph1); addr = 4'd5; cellState = 2'b11;
        e = exp_q.pop_front();
        checks++;
        if (wrAck !== e.ack || wrReject !== e.rej) begin
            errors++;
            $display("FAIL b2b_first got ack=%b rej=%b exp ack=%b rej=%b", wrAck, wrReject, e.ack, e.rej);
        end
        exp_q.push_back('{ack: 1'b0, rej: 1'b1});
        @(negedge ph1); wrEn = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (wrAck !== e.ack || wrReject !== e.rej) begin
            errors++;
            $display("FAIL b2b_in_check got ack=%b rej=%b exp ack=%b rej=%b", wrAck, wrReject, e.ack, e.rej);
        end
        mb[4] = 2'b10;
        rdAddr = 4'd5; #1;
        checks++;
        if (rdState !== 2'b00) begin
            errors++;
            $display("FAIL b2b_board got %b exp 00", rdState);
        end
        repeat (7) @(negedge ph1);
        checks++;
        if (checkBusy !== 1'b0 || gameIsDone !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", checkBusy, gameIsDone);
        end
    endtask

    task automatic test_newgame_collision();
        start_new_game();
        do_move(4'd0, 2'b11); do_move(4'd4, 2'b11); do_move(4'd8, 2'b11);
        do_move(4'd5, 2'b10);
        @(negedge ph1); newGame = 1'b1; wrEn = 1'b1; addr = 4'd6; cellState = 2'b10;
        @(negedge ph1); newGame = 1'b0; wrEn = 1'b0;
        model_clear();
        rdAddr = 4'd6; #1;
        checks++;
        if ({wrAck, wrReject, gameIsDone, winner, rdState} !== 7'b0000000) begin
            errors++;
            $display("FAIL newgame_wr got ack=%b rej=%b done=%b win=%b rd6=%b exp all 0",
                     wrAck, wrReject, gameIsDone, winner, rdState);
        end
        rdAddr = 4'd4; #1;
        checks++;
        if (rdState !== 2'b00) begin
            errors++;
            $display("FAIL newgame_clear got %b exp 00", rdState);
        end
    endtask

    task automatic test_reset_mid_check();
        start_new_game();
        do_move(4'd0, 2'b10); do_move(4'd1, 2'b10);
        @(negedge ph1); wrEn = 1'b1; addr = 4'd2; cellState = 2'b10;
        @(negedge ph1); wrEn = 1'b0;
        repeat (2) @(negedge ph1);
        reset_n = 1'b0;
        rdAddr = 4'd0;
        #1;
        checks++;
        if ({wrAck, wrReject, checkBusy, gameIsDone, winner, rdState} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid got %b exp 00000000",
                     {wrAck, wrReject, checkBusy, gameIsDone, winner, rdState});
        end
        @(negedge ph1); reset_n = 1'b1;
        model_clear();
        repeat (10) @(negedge ph1);
        checks++;
        if (gameIsDone !== 1'b0 || checkBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon got done=%b busy=%b exp 0 0", gameIsDone, checkBusy);
        end
    endtask

`ifdef GAME_BOARD_SCORE_EN
    task automatic test_score_saturate();
        int ex;
        for (int n = 1; n <= 16; n++) begin
            start_new_game();
            do_move(4'd0, 2'b10); do_move(4'd1, 2'b10); do_move(4'd2, 2'b10);
            ex = (n > 15) ? 15 : n;
            checks++;
            if (xWins !== ex[3:0] || oWins !== 4'd0 || draws !== 4'd0) begin
                errors++;
                $display("FAIL score n=%0d got x=%0d o=%0d d=%0d exp x=%0d o=0 d=0",
                         n, xWins, oWins, draws, ex);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_row_win();
        test_reject();
        test_draw();
        test_back_to_back();
        test_newgame_collision();
        test_reset_mid_check();
`ifdef GAME_BOARD_SCORE_EN
        test_score_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
